ap_ctrl_perf_monitor: RTL and testbench

- Synthesizable, parametrised successor to the simulation-only module-status monitor.
- Observes the ap_start/ap_ready/ap_done/ap_continue handshake of N_CH HLS modules, e.g. MPSQ top, mSP_findBounds, get_index_from_z.
- Keeps per-channel transaction statistics in hardware: latency, busy cycles and continue-stall cycles.
- Statistics are read through a registered indexed readout port. Capture freezes on `finish`, so an on-chip or co-sim harness can dump results without a testbench class hierarchy.

---
 rtl/ap_ctrl_perf_monitor.sv | 149 ++++++++++++++
 tb/tb_ap_ctrl_perf_monitor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_perf_monitor.sv
// Hardware monitor for N_CH ap_ctrl handshakes: per-channel latency, busy and
// continue-stall statistics with sticky protocol errors and a registered readout.
module ap_ctrl_perf_monitor #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 32,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_ready,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  input  logic             finish,
  input  logic             clear,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state     [N_CH];
  logic [CNT_W-1:0] lat_cnt   [N_CH];
  logic [CNT_W-1:0] txn       [N_CH];
  logic [CNT_W-1:0] last      [N_CH];
  logic [CNT_W-1:0] max_lat   [N_CH];
  logic [CNT_W-1:0] min_lat   [N_CH];
  logic [CNT_W-1:0] busy_tot  [N_CH];
  logic [CNT_W-1:0] stall_tot [N_CH];
  logic [2:0]       ovf       [N_CH];

  logic [N_CH-1:0]  rec;
  logic [CNT_W-1:0] rec_len   [N_CH];
  logic [CNT_W-1:0] rd_mux;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ONES) ? v : v + ONE;
  endfunction

  // Which channels complete a transaction this cycle, and with what latency
  always_comb begin
    rec = '0;
    for (int i = 0; i < N_CH; i++) begin
      rec_len[i] = '0;
      case (state[i])
        IDLE: if (ap_start[i] && ap_done[i] && ap_continue[i]) begin
          rec[i]     = 1'b1;
          rec_len[i] = ONE;
        end
        RUN: if (ap_done[i] && ap_continue[i]) begin
          rec[i]     = 1'b1;
          rec_len[i] = sat_inc(lat_cnt[i]);
        end
        HOLD: if (ap_continue[i]) begin
          rec[i]     = 1'b1;
          rec_len[i] = lat_cnt[i];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset || clear) begin
        state[i]     <= IDLE;
        lat_cnt[i]   <= '0;
        txn[i]       <= '0;
        last[i]      <= '0;
        max_lat[i]   <= '0;
        min_lat[i]   <= ONES;
        busy_tot[i]  <= '0;
        stall_tot[i] <= '0;
        ovf[i]       <= '0;
        err[i]       <= 1'b0;
      end else if (!finish) begin
        if (ap_ready[i] && !ap_start[i]) err[i] <= 1'b1;
        case (state[i])
          IDLE: begin
            if (ap_start[i] && !ap_done[i]) begin
              state[i]   <= RUN;
              lat_cnt[i] <= ONE;
            end else if (ap_start[i] && ap_done[i] && !ap_continue[i]) begin
              state[i]   <= HOLD;
              lat_cnt[i] <= ONE;
            end else if (ap_done[i] && !ap_start[i]) begin
              err[i] <= 1'b1;
            end
          end
          RUN: begin
            lat_cnt[i]  <= sat_inc(lat_cnt[i]);
            busy_tot[i] <= sat_inc(busy_tot[i]);
            if (busy_tot[i] == ONES) ovf[i][1] <= 1'b1;
            if (ap_done[i]) state[i] <= ap_continue[i] ? IDLE : HOLD;
          end
          HOLD: begin
            stall_tot[i] <= sat_inc(stall_tot[i]);
            if (stall_tot[i] == ONES) ovf[i][2] <= 1'b1;
            if (!ap_done[i]) err[i] <= 1'b1;
            if (ap_continue[i]) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase
        if (rec[i]) begin
          txn[i]  <= sat_inc(txn[i]);
          if (txn[i] == ONES) ovf[i][0] <= 1'b1;
          last[i] <= rec_len[i];
          if (rec_len[i] > max_lat[i]) max_lat[i] <= rec_len[i];
          if (rec_len[i] < min_lat[i]) min_lat[i] <= rec_len[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) busy[i] = (state[i] != IDLE);
  end

  // Readout select; unmatched channel numbers fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_sel)
          3'd0: rd_mux = txn[i];
          3'd1: rd_mux = last[i];
          3'd2: rd_mux = min_lat[i];
          3'd3: rd_mux = max_lat[i];
          3'd4: rd_mux = busy_tot[i];
          3'd5: rd_mux = stall_tot[i];
          3'd6: rd_mux = {{(CNT_W-6){1'b0}}, err[i], ovf[i], state[i]};
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Scoreboard bench for ap_ctrl_perf_monitor: directed handshake scenarios plus
// randomized traffic, checked against a count-based reference model.
module tb_ap_ctrl_perf_monitor;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int MX = 255;

  logic         clock = 1'b0;
  logic         reset, finish, clear;
  logic [N-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic [1:0]   rd_ch;
  logic [2:0]   rd_sel;
  logic [W-1:0] rd_data;
  logic [N-1:0] busy, err;

  always #5 clock = ~clock;

  ap_ctrl_perf_monitor #(.N_CH(N), .CNT_W(W)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
    .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .err(err)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] rd;
    logic [N-1:0] bz;
    logic [N-1:0] er;
    string        nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0, bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: true (unbounded) counts, saturated only when observed
  int m_txn[N], m_busy[N], m_stall[N], m_lat[N];
  int m_last[N], m_max[N], m_min[N], m_ph[N];
  bit m_err[N];

  function automatic int sat(input int x);
    return (x > MX) ? MX : x;
  endfunction

  function automatic logic [W-1:0] model_read(input int ch, input int sel);
    int v;
    if (ch >= N) return '0;
    case (sel)
      0: v = sat(m_txn[ch]);
      1: v = m_last[ch];
      2: v = m_min[ch];
      3: v = m_max[ch];
      4: v = sat(m_busy[ch]);
      5: v = sat(m_stall[ch]);
      6: v = (m_err[ch] ? 32 : 0) + (m_stall[ch] > MX ? 16 : 0) +
             (m_busy[ch] > MX ? 8 : 0) + (m_txn[ch] > MX ? 4 : 0) + m_ph[ch];
      default: v = 0;
    endcase
    return W'(v);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      m_txn[c] = 0; m_busy[c] = 0; m_stall[c] = 0; m_lat[c] = 0;
      m_last[c] = 0; m_max[c] = 0; m_min[c] = MX; m_ph[c] = 0; m_err[c] = 0;
    end
  endtask

  task automatic record(input int c, input int len);
    int s;
    s = sat(len);
    m_txn[c]++;
    m_last[c] = s;
    if (s > m_max[c]) m_max[c] = s;
    if (s < m_min[c]) m_min[c] = s;
  endtask

  task automatic model_step();
    if (reset || clear) begin
      model_clear();
      return;
    end
    if (finish) return;
    for (int c = 0; c < N; c++) begin
      bit s, r, d, k;
      s = ap_start[c]; r = ap_ready[c]; d = ap_done[c]; k = ap_continue[c];
      if (r && !s) m_err[c] = 1;
      case (m_ph[c])
        0: begin
          if (s && !d) begin m_ph[c] = 1; m_lat[c] = 1; end
          else if (s && d && k) record(c, 1);
          else if (s && d) begin m_ph[c] = 2; m_lat[c] = 1; end
          else if (d) m_err[c] = 1;
        end
        1: begin
          m_busy[c]++;
          m_lat[c]++;
          if (d && k) begin record(c, m_lat[c]); m_ph[c] = 0; end
          else if (d) m_ph[c] = 2;
        end
        default: begin
          m_stall[c]++;
          if (!d) m_err[c] = 1;
          if (k) begin record(c, m_lat[c]); m_ph[c] = 0; end
        end
      endcase
    end
  endtask

  // One clock: queue the expected response, advance the model, cross the edge
  task automatic step(input string nm, input bit use_k, input logic [W-1:0] k);
    exp_t e;
    e.cyc = cyc;
    e.nm  = nm;
    if (reset) e.rd = '0;
    else       e.rd = use_k ? k : model_read(int'(rd_ch), int'(rd_sel));
    model_step();
    for (int c = 0; c < N; c++) begin
      e.bz[c] = (m_ph[c] != 0);
      e.er[c] = m_err[c];
    end
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic cyc1(input string nm);
    rd_ch  = 2'($urandom_range(0, 3));
    rd_sel = 3'($urandom_range(0, 7));
    step(nm, 1'b0, '0);
  endtask

  task automatic chk(input int ch, input int sel, input logic [W-1:0] v, input string nm);
    rd_ch  = 2'(ch);
    rd_sel = 3'(sel);
    step(nm, 1'b1, v);
  endtask

  task automatic idle_in();
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    finish = 1'b0; clear = 1'b0;
  endtask

  task automatic start_on(input int c);
    ap_start[c] = 1'b1;
    ap_ready[c] = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        total++;
        if (rd_data !== e.rd) begin
          bad++;
          $display("FAIL %s rd_data got=%0h want=%0h (cycle %0d)", e.nm, rd_data, e.rd, e.cyc);
        end
        total++;
        if (busy !== e.bz) begin
          bad++;
          $display("FAIL %s busy got=%b want=%b (cycle %0d)", e.nm, busy, e.bz, e.cyc);
        end
        total++;
        if (err !== e.er) begin
          bad++;
          $display("FAIL %s err got=%b want=%b (cycle %0d)", e.nm, err, e.er, e.cyc);
        end
      end
    end
  end

  initial begin : driver
    int lats[3];
    lats = '{3, 7, 2};
    idle_in();
    reset = 1'b1; rd_ch = '0; rd_sel = '0;
    model_clear();
    #1;
    repeat (3) cyc1("reset");
    reset = 1'b0;
    chk(0, 2, 8'hFF, "min_init");
    chk(0, 0, 8'h00, "txn_init");

    // Four-cycle-gap transaction on ch0
    start_on(0); cyc1("t1_start"); idle_in();
    repeat (3) cyc1("t1_run");
    ap_done[0] = 1'b1; cyc1("t1_done"); idle_in();
    chk(0, 0, 8'd1, "t1_txn");
    chk(0, 1, 8'd5, "t1_last");
    chk(0, 2, 8'd5, "t1_min");
    chk(0, 3, 8'd5, "t1_max");
    chk(0, 4, 8'd4, "t1_busy");
    chk(0, 5, 8'd0, "t1_stall");

    // Same latency, then three HOLD cycles before continue
    start_on(0); cyc1("h_start"); idle_in();
    repeat (3) cyc1("h_run");
    ap_done[0] = 1'b1; ap_continue[0] = 1'b0;
    repeat (3) cyc1("h_hold");
    ap_continue[0] = 1'b1; cyc1("h_release"); idle_in();
    chk(0, 1, 8'd5, "h_last");
    chk(0, 5, 8'd3, "h_stall");
    chk(0, 0, 8'd2, "h_txn");
    chk(0, 4, 8'd8, "h_busy");

    // Zero-latency completion on ch2
    start_on(2); ap_done[2] = 1'b1; cyc1("z_cycle"); idle_in();
    chk(2, 0, 8'd1, "z_txn");
    chk(2, 1, 8'd1, "z_last");
    chk(2, 6, 8'h00, "z_state");

    // Back-to-back on ch1
    for (int t = 0; t < 3; t++) begin
      start_on(1); cyc1("b2b_start"); idle_in();
      repeat (lats[t] - 2) cyc1("b2b_run");
      ap_done[1] = 1'b1; cyc1("b2b_done"); idle_in();
    end
    chk(1, 0, 8'd3, "b2b_txn");
    chk(1, 1, 8'd2, "b2b_last");
    chk(1, 2, 8'd2, "b2b_min");
    chk(1, 3, 8'd7, "b2b_max");
    chk(1, 6, 8'h00, "b2b_err");

    // Protocol errors
    ap_done[0] = 1'b1; cyc1("e_done_idle"); idle_in();
    chk(0, 6, 8'h20, "e_ch0_err");
    chk(0, 0, 8'd2, "e_ch0_txn");
    ap_ready[1] = 1'b1; cyc1("e_ready"); idle_in();
    chk(1, 6, 8'h20, "e_ch1_err");
    chk(0, 6, 8'h20, "e_ch0_sticky");

    // Freeze mid-RUN, then clear coincident with done
    start_on(0); cyc1("f_start"); idle_in();
    repeat (2) cyc1("f_run");
    finish = 1'b1;
    repeat (20) cyc1("f_frozen");
    chk(0, 4, 8'd10, "f_busy_frozen");
    chk(0, 6, 8'h21, "f_state_frozen");
    finish = 1'b0;
    repeat (3) cyc1("f_resume");
    ap_done[0] = 1'b1; clear = 1'b1; cyc1("f_clear_done"); idle_in();
    chk(0, 0, 8'd0, "c_txn");
    chk(0, 2, 8'hFF, "c_min");
    chk(0, 4, 8'd0, "c_busy");
    chk(0, 6, 8'h00, "c_ch0_flags");
    chk(1, 6, 8'h00, "c_ch1_flags");

    // 300-cycle transaction saturates latency and busy_tot
    start_on(1); cyc1("s_start"); idle_in();
    repeat (298) cyc1("s_run");
    ap_done[1] = 1'b1; cyc1("s_done"); idle_in();
    chk(1, 1, 8'd255, "s_last");
    chk(1, 4, 8'd255, "s_busy");
    chk(1, 6, 8'h08, "s_flags");
    chk(1, 0, 8'd1, "s_txn");
    chk(3, 0, 8'd0, "oor_ch");
    chk(0, 7, 8'd0, "sel7");

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < N; c++) begin
        ap_start[c]    = ($urandom_range(0, 9) < 3);
        ap_done[c]     = ($urandom_range(0, 9) < 3);
        ap_continue[c] = ($urandom_range(0, 9) < 7);
        ap_ready[c]    = ap_start[c] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      end
      if ($urandom_range(0, 19) == 0) finish = ~finish;
      clear = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 999) == 0);
      cyc1("rand");
    end
    idle_in();
    reset = 1'b0;
    cyc1("tail");

    for (int w = 0; w < 20 && q.size() > 0; w++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
